change_dispenser: RTL and testbench
===================================

# change_dispenser

Controller that sequences the change-return datapath of the vending machine. On a start strobe it takes the change amount in kop and pays it out greedily from a per-denomination coin stock, one coin per `o_change_strobe` pulse. It finishes with a done pulse and a no-change flag. The stock is replenished by coins accepted from the customer.

## Interface
- `CURRENCIES`, 8: number of denominations. Code 0..7 maps to 1, 2, 5, 10, 25, 50, 100, 200 kop, ascending.
- `AMOUNT_W`, 16: width of amount and remaining in kop.
- `COUNT_W`, 8: width of each stock counter.
- `INIT_COUNT`, 10: stock of every denomination after reset.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_start`  in  1  one-cycle request; honoured only in IDLE.
- `i_amount`  in  AMOUNT_W  change to return in kop; sampled with `i_start`.
- `i_refill_strobe`  in  1  add one coin to stock.
- `i_refill_code`  in  $clog2(CURRENCIES)  denomination of the refilled coin.
- `o_busy`  out  1  high from the cycle after an accepted start through DONE.
- `o_change`  out  $clog2(CURRENCIES)  code of the coin being paid; valid with the strobe.
- `o_change_strobe`  out  1  one coin paid this cycle.
- `o_done`  out  1  one-cycle completion pulse.
- `o_no_change`  out  1  set in DONE when remaining ≠ 0; held until the next accepted start.
- `o_remaining`  out  AMOUNT_W  amount still owed; updated per coin.

## Operation
States and transitions:
- IDLE: on `i_start`, latch `i_amount` into remaining, clear `o_no_change`, go to SEARCH.
- SEARCH: find the highest code k with stock[k] > 0 and VALUE[k] ≤ remaining.
  - remaining = 0 → DONE.
  - No such k → DONE with `o_no_change` = 1.
  - Otherwise register k and go to EMIT.
- EMIT: `o_change_strobe` = 1 and `o_change` = k for one cycle; stock[k]−−; remaining −= VALUE[k]; go to SEARCH.
- DONE: `o_done` = 1 for one cycle; go to IDLE.

Rules:
- Selection is greedy with no backtracking. A greedy failure is reported as no-change even if some other combination would have succeeded.
- Refill is accepted in any state. A stock counter saturates at 2^COUNT_W−1; a refill to a full counter is dropped.
- Refill and decrement on the same code in the same cycle: count unchanged.
- `i_start` outside IDLE is ignored.
- Arithmetic: remaining never underflows, because VALUE[k] ≤ remaining is guaranteed by selection. Values are compared zero-extended to AMOUNT_W.

## Timing
- Reset (synchronous, effective at the sampling edge):
  - State goes to IDLE; every stock counter to INIT_COUNT.
  - `o_busy`, `o_change`, `o_change_strobe`, `o_done`, `o_no_change` and `o_remaining` all go to 0.
  - Reset mid-dispense aborts immediately: no further strobes, and coins already paid are not restored beyond the stock reload.
- Cycle numbering: start is sampled in cycle 0. Cycle 1 is SEARCH; the first strobe is in cycle 2.
- Each coin costs 2 cycles. N coins give `o_done` in cycle 2N+2; amount 0 gives `o_done` in cycle 2.
- Strobes are never adjacent: at least one idle cycle separates them.
- `o_remaining` reflects the decrement from the cycle after the strobe.
- `o_busy` is low in the cycle after DONE, so a new start can be accepted in that cycle.

## Structure
- Package `vending_pkg`:
  - `CURRENCIES`
  - `CURRENCY_VALUES` array, shared with the machine and the bench
  - state enum {IDLE, SEARCH, EMIT, DONE}
- Sub-module `coin_selector`: combinational priority picker.
  - Inputs: stock-nonzero vector and remaining.
  - Outputs: found and code.
- Top level: FSM, stock counter array, remaining register.

## Test plan
- Reset, `i_amount` = 385 → codes 7, 6, 5, 4, 3 (200 + 100 + 50 + 25 + 10); `o_done` in cycle 12; `o_no_change` = 0; `o_remaining` = 0; stock[7] = 9.
- `i_amount` = 0 → no strobes; `o_done` in cycle 2; `o_no_change` = 0.
- Stock exhaustion, `i_amount` = 3000 → 10× code 7 then 10× code 6; stock[7] = stock[6] = 0. Then `i_amount` = 300 → 6× code 5.
- `INIT_COUNT` = 0, refill code 5 once, `i_amount` = 30 → zero strobes; `o_done` with `o_no_change` = 1; `o_remaining` = 30.
- Refill code 7 during the EMIT of code 7 → stock[7] unchanged. `i_start` while busy → ignored, and the amount is not re-latched.
- Assert `i_rst_n` = 0 in the cycle after the 2nd strobe → no further strobes; all outputs 0; stock back to INIT_COUNT.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine: denomination table and the
// change-dispenser state encoding.
package vending_pkg;

  localparam int CURRENCIES = 8;

  // Coin values in kop, indexed by denomination code, ascending.
  localparam int unsigned CURRENCY_VALUES [CURRENCIES] = '{1, 2, 5, 10, 25, 50, 100, 200};

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/coin_selector.sv
// Combinational priority picker: returns the highest denomination that is in
// stock and does not exceed the amount still owed.
module coin_selector
  import vending_pkg::*;
#(
  parameter int AMOUNT_W = 16
) (
  input  logic [CURRENCIES-1:0]         stock_nz,
  input  logic [AMOUNT_W-1:0]           remaining,
  output logic                          found,
  output logic [$clog2(CURRENCIES)-1:0] code
);

  localparam int CODE_W = $clog2(CURRENCIES);

  // Ascending scan so the last hit, i.e. the largest coin, wins.
  always_comb begin
    found = 1'b0;
    code  = '0;
    for (int i = 0; i < CURRENCIES; i++) begin
      if (stock_nz[i] && (AMOUNT_W'(CURRENCY_VALUES[i]) <= remaining)) begin
        found = 1'b1;
        code  = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change-return sequencer: pays an amount greedily from per-denomination coin
// stock, one coin per strobe, then pulses done and flags any shortfall.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int CURRENCIES = vending_pkg::CURRENCIES,
  parameter int AMOUNT_W   = 16,
  parameter int COUNT_W    = 8,
  parameter int INIT_COUNT = 10
) (
  input  logic                          clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [AMOUNT_W-1:0]           i_amount,
  input  logic                          i_refill_strobe,
  input  logic [$clog2(CURRENCIES)-1:0] i_refill_code,
  output logic                          o_busy,
  output logic [$clog2(CURRENCIES)-1:0] o_change,
  output logic                          o_change_strobe,
  output logic                          o_done,
  output logic                          o_no_change,
  output logic [AMOUNT_W-1:0]           o_remaining
);

  localparam int CODE_W = $clog2(CURRENCIES);

  state_t                state;
  logic [COUNT_W-1:0]    stock_q [CURRENCIES];
  logic [CURRENCIES-1:0] stock_nz;
  logic [CURRENCIES-1:0] take;
  logic [CURRENCIES-1:0] add_hit;
  logic                  sel_found;
  logic [CODE_W-1:0]     sel_code;

  always_comb begin
    stock_nz = '0;
    take     = '0;
    add_hit  = '0;
    for (int i = 0; i < CURRENCIES; i++) begin
      stock_nz[i] = (stock_q[i] != '0);
      take[i]     = (state == EMIT) && (o_change == CODE_W'(i));
      add_hit[i]  = i_refill_strobe && (i_refill_code == CODE_W'(i));
    end
  end

  coin_selector #(
    .AMOUNT_W (AMOUNT_W)
  ) u_selector (
    .stock_nz  (stock_nz),
    .remaining (o_remaining),
    .found     (sel_found),
    .code      (sel_code)
  );

  // A refill landing on the coin being paid out cancels the decrement, even
  // when that counter is full, so the count simply holds.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CURRENCIES; i++) begin
      if (!i_rst_n) begin
        stock_q[i] <= COUNT_W'(INIT_COUNT);
      end else if (take[i]) begin
        if (!add_hit[i]) begin
          stock_q[i] <= stock_q[i] - COUNT_W'(1);
        end
      end else if (add_hit[i] && (stock_q[i] != '1)) begin
        stock_q[i] <= stock_q[i] + COUNT_W'(1);
      end
    end
  end

  // o_change holds the selected code through EMIT so the stock decrement and
  // the remaining update both key off the registered value.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      o_busy          <= 1'b0;
      o_change        <= '0;
      o_change_strobe <= 1'b0;
      o_done          <= 1'b0;
      o_no_change     <= 1'b0;
      o_remaining     <= '0;
    end else begin
      o_change_strobe <= 1'b0;
      o_done          <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            o_remaining <= i_amount;
            o_no_change <= 1'b0;
            o_busy      <= 1'b1;
            state       <= SEARCH;
          end
        end
        SEARCH: begin
          if (o_remaining == '0) begin
            o_done <= 1'b1;
            state  <= DONE;
          end else if (!sel_found) begin
            o_done      <= 1'b1;
            o_no_change <= 1'b1;
            state       <= DONE;
          end else begin
            o_change        <= sel_code;
            o_change_strobe <= 1'b1;
            state           <= EMIT;
          end
        end
        EMIT: begin
          o_remaining <= o_remaining - AMOUNT_W'(CURRENCY_VALUES[o_change]);
          state       <= SEARCH;
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a default-stock instance and an
// empty-stock instance share the stimulus, selected by use0.
module tb_change_dispenser;
  import vending_pkg::*;

  typedef struct packed {
    logic        is_done;
    logic [2:0]  code;
    logic        no_change;
    logic [15:0] rem;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] amount;
  logic        refill;
  logic [2:0]  refill_code;
  logic        use0;

  logic        busy_a, strobe_a, done_a, nc_a;
  logic [2:0]  change_a;
  logic [15:0] rem_a;
  logic        busy_b, strobe_b, done_b, nc_b;
  logic [2:0]  change_b;
  logic [15:0] rem_b;

  logic        m_busy, m_strobe, m_done, m_no_change;
  logic [2:0]  m_change;
  logic [15:0] m_remaining;
  logic        start_a, start_b, refill_a, refill_b;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  logic prev_strobe = 1'b0;

  always #5 clk = ~clk;

  assign start_a  = start && !use0;
  assign start_b  = start && use0;
  assign refill_a = refill && !use0;
  assign refill_b = refill && use0;

  assign m_busy      = use0 ? busy_b   : busy_a;
  assign m_strobe    = use0 ? strobe_b : strobe_a;
  assign m_done      = use0 ? done_b   : done_a;
  assign m_no_change = use0 ? nc_b     : nc_a;
  assign m_change    = use0 ? change_b : change_a;
  assign m_remaining = use0 ? rem_b    : rem_a;

  change_dispenser #(
    .CURRENCIES (8), .AMOUNT_W (16), .COUNT_W (8), .INIT_COUNT (10)
  ) dut (
    .clk (clk), .i_rst_n (rst_n), .i_start (start_a), .i_amount (amount),
    .i_refill_strobe (refill_a), .i_refill_code (refill_code),
    .o_busy (busy_a), .o_change (change_a), .o_change_strobe (strobe_a),
    .o_done (done_a), .o_no_change (nc_a), .o_remaining (rem_a)
  );

  change_dispenser #(
    .CURRENCIES (8), .AMOUNT_W (16), .COUNT_W (8), .INIT_COUNT (0)
  ) dut0 (
    .clk (clk), .i_rst_n (rst_n), .i_start (start_b), .i_amount (amount),
    .i_refill_strobe (refill_b), .i_refill_code (refill_code),
    .o_busy (busy_b), .o_change (change_b), .o_change_strobe (strobe_b),
    .o_done (done_b), .o_no_change (nc_b), .o_remaining (rem_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic expectCoin(input logic [2:0] code, input int rem);
    ev_t e;
    e.is_done = 1'b0; e.code = code; e.no_change = 1'b0; e.rem = 16'(rem);
    exp_q.push_back(e);
  endtask

  task automatic expectDone(input logic nc, input int rem);
    ev_t e;
    e.is_done = 1'b1; e.code = 3'd0; e.no_change = nc; e.rem = 16'(rem);
    exp_q.push_back(e);
  endtask

  // Issues one start and counts cycles to done; optionally injects a refill
  // or a spurious start in a given cycle (-1 disables).
  task automatic applyStimulus(input int amt, input int exp_cyc, input int refill_cyc,
                               input logic [2:0] rcode, input int busy_cyc);
    int cyc;
    @(posedge clk); #1;
    start = 1'b1; amount = 16'(amt); cyc = 0;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0; refill = 1'b0;
      if (m_done) break;
      if (cyc == refill_cyc) begin refill = 1'b1; refill_code = rcode; end
      if (cyc == busy_cyc) begin start = 1'b1; amount = 16'd5; end
    end
    start = 1'b0; refill = 1'b0;
    checkOutput("done_cycle", 32'(cyc), 32'(exp_cyc));
    checkOutput("busy_in_done", 32'(m_busy), 32'd1);
    @(posedge clk); #1;
    checkOutput("busy_after_done", 32'(m_busy), 32'd0);
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every strobe or done pops the next expected event.
  always @(negedge clk) begin
    ev_t e;
    if (m_strobe) checkOutput("strobe_gap", 32'(prev_strobe), 32'd0);
    prev_strobe <= m_strobe;
    if (m_strobe || m_done) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("[TB] FAIL unexpected_output: got strobe=%0b done=%0b code=%0d, required none",
                 m_strobe, m_done, m_change);
      end else begin
        e = exp_q.pop_front();
        checkOutput("event_kind", 32'(m_done), 32'(e.is_done));
        if (e.is_done) begin
          checkOutput("no_change", 32'(m_no_change), 32'(e.no_change));
          checkOutput("done_remaining", 32'(m_remaining), 32'(e.rem));
        end else begin
          checkOutput("coin_code", 32'(m_change), 32'(e.code));
          checkOutput("coin_remaining", 32'(m_remaining), 32'(e.rem));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; amount = '0; refill = 1'b0; refill_code = '0; use0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_strobe", 32'(strobe_a), 32'd0);
    checkOutput("rst_done", 32'(done_a), 32'd0);
    checkOutput("rst_no_change", 32'(nc_a), 32'd0);
    checkOutput("rst_change", 32'(change_a), 32'd0);
    checkOutput("rst_remaining", 32'(rem_a), 32'd0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("rst_stock", 32'(dut.stock_q[i]), 32'd10);
      checkOutput("rst_stock0", 32'(dut0.stock_q[i]), 32'd0);
    end
    rst_n = 1'b1;

    $display("[TB] 385 kop from full stock");
    expectCoin(7, 385); expectCoin(6, 185); expectCoin(5, 85);
    expectCoin(4, 35);  expectCoin(3, 10);  expectDone(0, 0);
    applyStimulus(385, 12, -1, 3'd0, -1);
    checkOutput("stock7_after_385", 32'(dut.stock_q[7]), 32'd9);

    $display("[TB] zero amount");
    expectDone(0, 0);
    applyStimulus(0, 2, -1, 3'd0, -1);

    $display("[TB] stock exhaustion");
    pulseReset();
    for (int i = 0; i < 10; i++) expectCoin(7, 3000 - 200 * i);
    for (int i = 0; i < 10; i++) expectCoin(6, 1000 - 100 * i);
    expectDone(0, 0);
    applyStimulus(3000, 42, -1, 3'd0, -1);
    checkOutput("stock7_empty", 32'(dut.stock_q[7]), 32'd0);
    checkOutput("stock6_empty", 32'(dut.stock_q[6]), 32'd0);
    for (int i = 0; i < 6; i++) expectCoin(5, 300 - 50 * i);
    expectDone(0, 0);
    applyStimulus(300, 14, -1, 3'd0, -1);

    $display("[TB] refill during emit, start while busy");
    pulseReset();
    expectCoin(7, 400); expectCoin(7, 200); expectDone(0, 0);
    applyStimulus(400, 6, 2, 3'd7, 3);
    checkOutput("stock7_refill_cancel", 32'(dut.stock_q[7]), 32'd9);

    $display("[TB] reset mid-dispense");
    expectCoin(7, 385); expectCoin(6, 185);
    @(posedge clk); #1;
    start = 1'b1; amount = 16'd385;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("abort_busy", 32'(busy_a), 32'd0);
    checkOutput("abort_strobe", 32'(strobe_a), 32'd0);
    checkOutput("abort_done", 32'(done_a), 32'd0);
    checkOutput("abort_no_change", 32'(nc_a), 32'd0);
    checkOutput("abort_change", 32'(change_a), 32'd0);
    checkOutput("abort_remaining", 32'(rem_a), 32'd0);
    for (int i = 0; i < 8; i++) checkOutput("abort_stock", 32'(dut.stock_q[i]), 32'd10);
    repeat (6) @(posedge clk);
    #1;

    $display("[TB] empty-stock instance");
    use0 = 1'b1;
    refill = 1'b1; refill_code = 3'd5;
    @(posedge clk); #1;
    refill = 1'b0;
    expectDone(1, 30);
    applyStimulus(30, 2, -1, 3'd0, -1);
    checkOutput("no_change_held", 32'(nc_b), 32'd1);
    expectCoin(5, 60); expectDone(1, 10);
    applyStimulus(60, 4, -1, 3'd0, -1);
    expectDone(0, 0);
    applyStimulus(0, 2, -1, 3'd0, -1);
    checkOutput("no_change_cleared", 32'(nc_b), 32'd0);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
